id_ex_alu_decode: RTL and testbench
===================================

Name: id_ex_alu_decode

Overview:
- Registered decode stage that produces the ALU's 6-bit function code and its two operands from a raw MIPS instruction plus register-file read data.
- Sits at the ID/EX boundary of the pipeline and drives the combinational execute ALU directly.
- Uses a one-entry valid/ready pipeline register, with stall and flush support.

Parameters:
- DATA_W, 32, operand/data width (the ALU is 32-bit; other values are unsupported).
- REG_W, 5, register-address width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept this cycle.
- i_instr  in  32  instruction word.
- i_rs_data  in  DATA_W  rs register value.
- i_rt_data  in  DATA_W  rt register value.
- i_flush  in  1  kill the held entry and any entry being offered this cycle.
- o_valid  out  1  outputs hold a decoded instruction.
- i_ready  in  1  execute stage accepts.
- o_alu_control  out  6  ALU function code.
- o_op1  out  DATA_W  ALU operand 1 (shift amount for shifts).
- o_op2  out  DATA_W  ALU operand 2.
- o_dest  out  REG_W  destination register.
- o_reg_write  out  1  write-back enable.
- o_ovf_trap_en  out  1  ALU overflow must trap (ADD, SUB, ADDI only).
- o_illegal  out  1  unsupported opcode/funct.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, o_alu_control=6'b000000.
- Reset asserted mid-transfer drops the held entry; no partial state survives.
- Latency: exactly 1 cycle, i_valid&&o_ready at edge N gives the outputs from edge N onward.
- Handshake:
  - o_ready = !o_valid || i_ready (combinational).
  - Load when i_valid&&o_ready; hold all outputs stable while o_valid&&!i_ready.
  - o_valid clears after a transfer (o_valid&&i_ready) with no new load.
- Flush: i_flush=1 clears o_valid at the next edge and suppresses any simultaneous load. Flush has priority over load and hold.
- Function codes:
  - AND 100100, OR 100101, ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, SLT 101010, SLTU 101011, NOR 100111, XOR 100110.
  - SLLV 000100, SRLV 000110, SRAV 000111, SLL 000000, SRL 000010, SRA 000011.
  - LUI 111100, ROTR 111110, ROTRV 111111.
- R-type (opcode 000000):
  - Funct passes through for the codes above; o_dest=rd; o_op2=rt_data.
  - SLL/SRL/SRA: o_op1 = zero-extended shamt (instr[10:6]).
  - SLLV/SRLV/SRAV: o_op1 = {27'b0, rs_data[4:0]}.
  - All other R-type: o_op1 = rs_data.
- I-type: o_dest=rt; o_op1=rs_data; sign-ext = {{16{imm[15]}},imm}; zero-ext = {16'b0,imm}.
  - 001000 ADDI→ADD, sign-ext.
  - 001001 ADDIU→ADDU, sign-ext.
  - 001010 SLTI→SLT, sign-ext.
  - 001011 SLTIU→SLTU, sign-ext.
  - 001100 ANDI→AND, zero-ext.
  - 001101 ORI→OR, zero-ext.
  - 001110 XORI→XOR, zero-ext.
  - 001111 LUI→LUI, o_op2 = zero-ext imm (the ALU performs the shift).
- o_reg_write = 1 for every legal decode, except forced 0 when o_dest==0 (so NOP 0x00000000 gives SLL with reg_write 0).
- Illegal opcode/funct: o_illegal=1, o_reg_write=0, o_ovf_trap_en=0, o_alu_control=000000, o_op1=o_op2=0. o_valid still asserts so the exception stage sees it.

Optional Feature:
- Macro: ALU_DEC_ROTATE_EN.
- Defined:
  - SRL with instr[21]=1 → ROTR (shamt operand).
  - SRLV with instr[6]=1 → ROTRV (rs[4:0] operand).
- Undefined:
  - Those bits are ignored; SRL/SRLV always decode as logical shifts.
  - Codes 111110/111111 are never emitted.

Decomposition:
- Shared package alu_pkg: the 6-bit ALU function-code constants, MIPS opcode constants, and the funct field/slice positions. The execute ALU reuses these constants.
- One natural sub-module: alu_dec_comb, the pure combinational instr→{control, op-select, ext-mode, dest, illegal} decoder.
- The top holds operand muxing and the valid/ready register.

Test Plan:
- ADDI r2,r1,-1 (0x2022FFFF), rs_data=5 → o_alu_control=100000, o_op1=5, o_op2=0xFFFFFFFF, o_dest=2, o_ovf_trap_en=1, one cycle later.
- ORI r2,r1,0x8000 (0x34228000) → control 100101, o_op2=0x00008000, o_ovf_trap_en=0; LUI (0x3C021234) → control 111100, o_op2=0x00001234.
- ROTR r3,r2,4 (0x00221902):
  - With macro: control 111110, o_op1=4, o_dest=3.
  - Without macro: control 000010.
- Backpressure: load, then i_ready=0 for 3 cycles with new i_valid → outputs frozen, o_ready=0; i_ready=1 → next instruction loads.
- i_flush=1 together with i_valid → o_valid=0 next cycle; NOP 0x00000000 → o_reg_write=0; opcode 0x3F → o_illegal=1.
- Assert i_rst_n=0 while o_valid=1 and i_ready=0 → o_valid=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU function codes, MIPS opcodes and instruction-field helpers.
// The execute ALU imports the same constants so both ends agree on the encoding.
package alu_pkg;

    localparam logic [5:0] ALU_SLL   = 6'b000000;
    localparam logic [5:0] ALU_SRL   = 6'b000010;
    localparam logic [5:0] ALU_SRA   = 6'b000011;
    localparam logic [5:0] ALU_SLLV  = 6'b000100;
    localparam logic [5:0] ALU_SRLV  = 6'b000110;
    localparam logic [5:0] ALU_SRAV  = 6'b000111;
    localparam logic [5:0] ALU_ADD   = 6'b100000;
    localparam logic [5:0] ALU_ADDU  = 6'b100001;
    localparam logic [5:0] ALU_SUB   = 6'b100010;
    localparam logic [5:0] ALU_SUBU  = 6'b100011;
    localparam logic [5:0] ALU_AND   = 6'b100100;
    localparam logic [5:0] ALU_OR    = 6'b100101;
    localparam logic [5:0] ALU_XOR   = 6'b100110;
    localparam logic [5:0] ALU_NOR   = 6'b100111;
    localparam logic [5:0] ALU_SLT   = 6'b101010;
    localparam logic [5:0] ALU_SLTU  = 6'b101011;
    localparam logic [5:0] ALU_LUI   = 6'b111100;
    localparam logic [5:0] ALU_ROTR  = 6'b111110;
    localparam logic [5:0] ALU_ROTRV = 6'b111111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [1:0] {OP1_RS, OP1_SHAMT, OP1_RS_LOW5, OP1_ZERO} op1_sel_e;
    typedef enum logic [1:0] {OP2_RT, OP2_IMM, OP2_ZERO} op2_sel_e;
    typedef enum logic {EXT_SIGN, EXT_ZERO} ext_mode_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] instr);
        return instr[20:16];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [4:0] shamt_of(input logic [31:0] instr);
        return instr[10:6];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/alu_dec_comb.sv
// Pure combinational MIPS instruction decoder: ALU code, operand selects, destination.
// Optional rotate decode is enabled by defining ALU_DEC_ROTATE_EN.
module alu_dec_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  alu_control,
    output op1_sel_e    op1_sel,
    output op2_sel_e    op2_sel,
    output ext_mode_e   ext_mode,
    output logic [4:0]  dest,
    output logic        reg_write,
    output logic        ovf_trap_en,
    output logic        illegal
);

    logic legal_s;

    // Opcode/funct decode; illegal encodings are squashed to all-zero controls at the end.
    always_comb begin
        alu_control = ALU_SLL;
        op1_sel     = OP1_ZERO;
        op2_sel     = OP2_ZERO;
        ext_mode    = EXT_SIGN;
        dest        = 5'd0;
        ovf_trap_en = 1'b0;
        legal_s     = 1'b1;
        reg_write   = 1'b0;
        case (opcode_of(instr))
            OP_RTYPE: begin
                alu_control = funct_of(instr);
                op1_sel     = OP1_RS;
                op2_sel     = OP2_RT;
                dest        = rd_of(instr);
                case (funct_of(instr))
                    ALU_ADD, ALU_SUB: ovf_trap_en = 1'b1;
                    ALU_ADDU, ALU_SUBU, ALU_AND, ALU_OR,
                    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU: ovf_trap_en = 1'b0;
                    ALU_SLL, ALU_SRA: op1_sel = OP1_SHAMT;
                    ALU_SRL: begin
                        op1_sel = OP1_SHAMT;
`ifdef ALU_DEC_ROTATE_EN
                        if (instr[21]) begin
                            alu_control = ALU_ROTR;
                        end else begin
                            alu_control = ALU_SRL;
                        end
`endif
                    end
                    ALU_SLLV, ALU_SRAV: op1_sel = OP1_RS_LOW5;
                    ALU_SRLV: begin
                        op1_sel = OP1_RS_LOW5;
`ifdef ALU_DEC_ROTATE_EN
                        if (instr[6]) begin
                            alu_control = ALU_ROTRV;
                        end else begin
                            alu_control = ALU_SRLV;
                        end
`endif
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                op1_sel = OP1_RS;
                op2_sel = OP2_IMM;
                dest    = rt_of(instr);
                case (opcode_of(instr))
                    OP_ADDI: begin
                        alu_control = ALU_ADD;
                        ovf_trap_en = 1'b1;
                    end
                    OP_ADDIU: alu_control = ALU_ADDU;
                    OP_SLTI:  alu_control = ALU_SLT;
                    OP_SLTIU: alu_control = ALU_SLTU;
                    OP_ANDI: begin
                        alu_control = ALU_AND;
                        ext_mode    = EXT_ZERO;
                    end
                    OP_ORI: begin
                        alu_control = ALU_OR;
                        ext_mode    = EXT_ZERO;
                    end
                    OP_XORI: begin
                        alu_control = ALU_XOR;
                        ext_mode    = EXT_ZERO;
                    end
                    default: begin
                        alu_control = ALU_LUI;
                        ext_mode    = EXT_ZERO;
                    end
                endcase
            end
            default: legal_s = 1'b0;
        endcase

        if (!legal_s) begin
            alu_control = 6'b000000;
            op1_sel     = OP1_ZERO;
            op2_sel     = OP2_ZERO;
            dest        = 5'd0;
            ovf_trap_en = 1'b0;
            reg_write   = 1'b0;
        end else begin
            reg_write = (dest != 5'd0);
        end
        illegal = !legal_s;
    end

endmodule

// File: rtl/id_ex_alu_decode.sv
// ID/EX registered decode stage: operand muxing and a one-entry valid/ready register.
// Optional rotate decode: define ALU_DEC_ROTATE_EN.
module id_ex_alu_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [5:0]        o_alu_control,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2,
    output logic [REG_W-1:0]  o_dest,
    output logic              o_reg_write,
    output logic              o_ovf_trap_en,
    output logic              o_illegal
);

    logic [5:0]        alu_control_s;
    op1_sel_e          op1_sel_s;
    op2_sel_e          op2_sel_s;
    ext_mode_e         ext_mode_s;
    logic [4:0]        dest_s;
    logic              reg_write_s;
    logic              ovf_trap_en_s;
    logic              illegal_s;
    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;
    logic              load_s;

    logic              valid_r;
    logic [5:0]        alu_control_r;
    logic [DATA_W-1:0] op1_r;
    logic [DATA_W-1:0] op2_r;
    logic [REG_W-1:0]  dest_r;
    logic              reg_write_r;
    logic              ovf_trap_en_r;
    logic              illegal_r;

    alu_dec_comb u_dec (
        .instr       (i_instr),
        .alu_control (alu_control_s),
        .op1_sel     (op1_sel_s),
        .op2_sel     (op2_sel_s),
        .ext_mode    (ext_mode_s),
        .dest        (dest_s),
        .reg_write   (reg_write_s),
        .ovf_trap_en (ovf_trap_en_s),
        .illegal     (illegal_s)
    );

    // Operand muxes driven by the decoder selects.
    always_comb begin
        op1_s = {DATA_W{1'b0}};
        op2_s = {DATA_W{1'b0}};
        case (op1_sel_s)
            OP1_RS:      op1_s = i_rs_data;
            OP1_SHAMT:   op1_s = {{(DATA_W-5){1'b0}}, shamt_of(i_instr)};
            OP1_RS_LOW5: op1_s = {{(DATA_W-5){1'b0}}, i_rs_data[4:0]};
            default:     op1_s = {DATA_W{1'b0}};
        endcase
        case (op2_sel_s)
            OP2_RT: op2_s = i_rt_data;
            OP2_IMM: begin
                if (ext_mode_s == EXT_SIGN) begin
                    op2_s = {{(DATA_W-16){i_instr[15]}}, i_instr[15:0]};
                end else begin
                    op2_s = {{(DATA_W-16){1'b0}}, i_instr[15:0]};
                end
            end
            default: op2_s = {DATA_W{1'b0}};
        endcase
    end

    assign o_ready = !valid_r || i_ready;
    assign load_s  = i_valid && o_ready;

    // Pipeline register: flush beats load, load beats drain, otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r       <= 1'b0;
            alu_control_r <= 6'b000000;
            op1_r         <= {DATA_W{1'b0}};
            op2_r         <= {DATA_W{1'b0}};
            dest_r        <= {REG_W{1'b0}};
            reg_write_r   <= 1'b0;
            ovf_trap_en_r <= 1'b0;
            illegal_r     <= 1'b0;
        end else if (i_flush) begin
            valid_r <= 1'b0;
        end else if (load_s) begin
            valid_r       <= 1'b1;
            alu_control_r <= alu_control_s;
            op1_r         <= op1_s;
            op2_r         <= op2_s;
            dest_r        <= dest_s;
            reg_write_r   <= reg_write_s;
            ovf_trap_en_r <= ovf_trap_en_s;
            illegal_r     <= illegal_s;
        end else if (i_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign o_valid       = valid_r;
    assign o_alu_control = alu_control_r;
    assign o_op1         = op1_r;
    assign o_op2         = op2_r;
    assign o_dest        = dest_r;
    assign o_reg_write   = reg_write_r;
    assign o_ovf_trap_en = ovf_trap_en_r;
    assign o_illegal     = illegal_r;

endmodule

// File: tb/tb_id_ex_alu_decode.sv
// Directed self-checking bench for id_ex_alu_decode; expectations follow ALU_DEC_ROTATE_EN.
module tb_id_ex_alu_decode;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_alu_control;
    logic [31:0] o_op1;
    logic [31:0] o_op2;
    logic [4:0]  o_dest;
    logic        o_reg_write;
    logic        o_ovf_trap_en;
    logic        o_illegal;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    id_ex_alu_decode dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_instr       (i_instr),
        .i_rs_data     (i_rs_data),
        .i_rt_data     (i_rt_data),
        .i_flush       (i_flush),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_alu_control (o_alu_control),
        .o_op1         (o_op1),
        .o_op2         (o_op2),
        .o_dest        (o_dest),
        .o_reg_write   (o_reg_write),
        .o_ovf_trap_en (o_ovf_trap_en),
        .o_illegal     (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  dest;
        logic        rw;
        logic        ovf;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

`ifdef ALU_DEC_ROTATE_EN
    localparam logic [5:0] EXP_ROTR  = 6'b111110;
    localparam logic [5:0] EXP_ROTRV = 6'b111111;
`else
    localparam logic [5:0] EXP_ROTR  = 6'b000010;
    localparam logic [5:0] EXP_ROTRV = 6'b000110;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check_val({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
        check_val({tag, ".ctrl"}, {26'd0, o_alu_control}, {26'd0, v.ctrl});
        check_val({tag, ".op1"}, o_op1, v.op1);
        check_val({tag, ".op2"}, o_op2, v.op2);
        check_val({tag, ".dest"}, {27'd0, o_dest}, {27'd0, v.dest});
        check_val({tag, ".rw"}, {31'd0, o_reg_write}, {31'd0, v.rw});
        check_val({tag, ".ovf"}, {31'd0, o_ovf_trap_en}, {31'd0, v.ovf});
        check_val({tag, ".ill"}, {31'd0, o_illegal}, {31'd0, v.ill});
    endtask

    task automatic drive(input vec_t v);
        i_instr   = v.instr;
        i_rs_data = v.rs;
        i_rt_data = v.rt;
    endtask

    initial begin
        vecs[0]  = '{"addi",  32'h2022FFFF, 32'h00000005, 32'h00000077, 6'b100000, 32'h00000005, 32'hFFFFFFFF, 5'd2, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{"ori",   32'h34228000, 32'h0F0F0000, 32'h00000011, 6'b100101, 32'h0F0F0000, 32'h00008000, 5'd2, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"lui",   32'h3C021234, 32'h0000AAAA, 32'h00000022, 6'b111100, 32'h0000AAAA, 32'h00001234, 5'd2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"rotr",  32'h00221902, 32'h12345678, 32'h9ABCDEF0, EXP_ROTR,  32'h00000004, 32'h9ABCDEF0, 5'd3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"nop",   32'h00000000, 32'h00000033, 32'h00000055, 6'b000000, 32'h00000000, 32'h00000055, 5'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"ill_op",32'hFC000000, 32'h00000001, 32'h00000002, 6'b000000, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{"sllv",  32'h00C52004, 32'hFFFFFF23, 32'h0000F00F, 6'b000100, 32'h00000003, 32'h0000F00F, 5'd4, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{"sub",   32'h00223822, 32'h00000100, 32'h00000020, 6'b100010, 32'h00000100, 32'h00000020, 5'd7, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{"sltiu", 32'h2D098001, 32'h00000009, 32'h00000044, 6'b101011, 32'h00000009, 32'hFFFF8001, 5'd9, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{"ill_fn",32'h00000001, 32'h00000007, 32'h00000008, 6'b000000, 32'h00000000, 32'h00000000, 5'd0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{"rotrv", 32'h00221846, 32'h00000025, 32'h0000ABCD, EXP_ROTRV, 32'h00000005, 32'h0000ABCD, 5'd3, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
        i_instr = 32'd0; i_rs_data = 32'd0; i_rt_data = 32'd0;
        #12;
        check_val("rst.valid", {31'd0, o_valid}, 32'd0);
        check_val("rst.ready", {31'd0, o_ready}, 32'd1);
        check_val("rst.ctrl", {26'd0, o_alu_control}, 32'd0);
        check_val("rst.op1", o_op1, 32'd0);
        check_val("rst.op2", o_op2, 32'd0);
        check_val("rst.rw", {31'd0, o_reg_write}, 32'd0);
        rst_n = 1'b1;
        step();

        // Streaming decode, one instruction per cycle
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i]);
            step();
            check_outputs(vecs[i].name, vecs[i]);
        end

        // Drain with no new load
        i_valid = 1'b0;
        step();
        check_val("drain.valid", {31'd0, o_valid}, 32'd0);

        // Backpressure: hold ADDI while ORI is offered
        i_valid = 1'b1;
        drive(vecs[0]);
        step();
        check_outputs("bp_load", vecs[0]);
        i_ready = 1'b0;
        drive(vecs[1]);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("bp.ready", {31'd0, o_ready}, 32'd0);
            step();
            check_outputs("bp_hold", vecs[0]);
        end
        i_ready = 1'b1;
        #1;
        check_val("bp.ready_rel", {31'd0, o_ready}, 32'd1);
        step();
        check_outputs("bp_next", vecs[1]);

        // Flush suppresses a simultaneous load
        i_flush = 1'b1;
        drive(vecs[2]);
        step();
        check_val("flush_load.valid", {31'd0, o_valid}, 32'd0);
        i_flush = 1'b0;

        // Flush kills a held entry under backpressure
        step();
        check_outputs("fl_held_load", vecs[2]);
        i_ready = 1'b0;
        i_valid = 1'b0;
        i_flush = 1'b1;
        step();
        check_val("flush_held.valid", {31'd0, o_valid}, 32'd0);
        i_flush = 1'b0;

        // Asynchronous reset while holding a stalled entry
        i_valid = 1'b1;
        drive(vecs[7]);
        step();
        i_valid = 1'b0;
        step();
        check_outputs("pre_rst", vecs[7]);
        rst_n = 1'b0;
        #1;
        check_val("arst.valid", {31'd0, o_valid}, 32'd0);
        check_val("arst.ctrl", {26'd0, o_alu_control}, 32'd0);
        check_val("arst.op1", o_op1, 32'd0);
        check_val("arst.op2", o_op2, 32'd0);
        check_val("arst.dest", {27'd0, o_dest}, 32'd0);
        check_val("arst.rw", {31'd0, o_reg_write}, 32'd0);
        check_val("arst.ovf", {31'd0, o_ovf_trap_en}, 32'd0);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
